// File: rtl/disp_pkg.sv
// Shared types and default sizes for the display write path.
package disp_pkg;

  localparam int N_DIG = 8;
  localparam int DW    = 4;

  typedef enum logic [1:0] {IDLE, MAN_WR, SHIFT, INSERT} wsched_state_t;
  typedef enum logic {MANUAL, SCROLL} req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter (manual vs scroll). Grants are
// combinational and only produced while en_i is high; the requester granted
// last loses the next tie.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic man_req_i,
  input  logic scr_req_i,
  output logic man_gnt_o,
  output logic scr_gnt_o
);
  import disp_pkg::*;

  req_id_t last_gnt_q, last_gnt_d;
  logic    gm, gs;

  // Pick a winner and compute the new last-granted owner.
  always_comb begin
    gm         = 1'b0;
    gs         = 1'b0;
    last_gnt_d = last_gnt_q;
    if (en_i) begin
      if (man_req_i && scr_req_i) begin
        if (last_gnt_q == SCROLL) gm = 1'b1;
        else                      gs = 1'b1;
      end else if (man_req_i) begin
        gm = 1'b1;
      end else if (scr_req_i) begin
        gs = 1'b1;
      end
      if (gm)      last_gnt_d = MANUAL;
      else if (gs) last_gnt_d = SCROLL;
    end
    man_gnt_o = gm;
    scr_gnt_o = gs;
  end

  // Remember the last grant; reset as SCROLL so manual wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_gnt_q <= SCROLL;
    else        last_gnt_q <= last_gnt_d;
  end

endmodule

// File: rtl/digit_write_scheduler.sv
// Owns the single write port of the digit register bank. Manual writes take
// one cycle; a scroll shifts every digit up one place (highest first, so each
// source is read before it is overwritten) and then inserts a new nibble at 0.
module digit_write_scheduler #(
  parameter  int N_DIG = disp_pkg::N_DIG,
  parameter  int DW    = disp_pkg::DW,
  localparam int SW    = $clog2(N_DIG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          man_req,
  input  logic [SW-1:0] man_sel,
  input  logic [DW-1:0] man_data,
  output logic          man_gnt,
  input  logic          scr_req,
  input  logic [DW-1:0] scr_data,
  output logic          scr_ack,
  output logic          scr_done,
  output logic          busy,
  output logic          wr_en,
  output logic [SW-1:0] wr_sel,
  output logic [DW-1:0] wr_data,
  output logic [SW-1:0] rd_sel,
  input  logic [DW-1:0] rd_data
);
  import disp_pkg::*;

  localparam logic [SW-1:0] IDX_TOP = SW'(N_DIG - 1);
  localparam logic [SW-1:0] IDX_ONE = SW'(1);

  wsched_state_t state_q;
  logic [SW-1:0] idx_q;
  logic [SW-1:0] sel_q;
  logic [DW-1:0] data_q;
  logic          scr_ack_q;
  logic          arb_man, arb_scr;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst),
    .en_i      (state_q == IDLE),
    .man_req_i (man_req),
    .scr_req_i (scr_req),
    .man_gnt_o (arb_man),
    .scr_gnt_o (arb_scr)
  );

  // Sequencer: accepts a request in IDLE, latches its operands, walks idx
  // down through the shift and finishes with the insert.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= IDX_TOP;
      sel_q     <= '0;
      data_q    <= '0;
      scr_ack_q <= 1'b0;
    end else begin
      scr_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_man) begin
            sel_q   <= man_sel;
            data_q  <= man_data;
            state_q <= MAN_WR;
          end else if (arb_scr) begin
            data_q    <= scr_data;
            idx_q     <= IDX_TOP;
            scr_ack_q <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        MAN_WR: state_q <= IDLE;
        SHIFT: begin
          if (idx_q == IDX_ONE) begin
            state_q <= INSERT;
          end else begin
            idx_q <= idx_q - IDX_ONE;
          end
        end
        INSERT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Moore decode of the write port and handshake pulses from the state.
  always_comb begin
    wr_en    = 1'b0;
    wr_sel   = '0;
    wr_data  = '0;
    rd_sel   = '0;
    man_gnt  = 1'b0;
    scr_done = 1'b0;
    case (state_q)
      MAN_WR: begin
        wr_en   = 1'b1;
        wr_sel  = sel_q;
        wr_data = data_q;
        man_gnt = 1'b1;
      end
      SHIFT: begin
        wr_en   = 1'b1;
        wr_sel  = idx_q;
        rd_sel  = idx_q - IDX_ONE;
        wr_data = rd_data;
      end
      INSERT: begin
        wr_en    = 1'b1;
        wr_sel   = '0;
        wr_data  = data_q;
        scr_done = 1'b1;
      end
      default: ;
    endcase
    busy    = (state_q != IDLE);
    scr_ack = scr_ack_q;
  end

endmodule

// File: tb/tb_digit_write_scheduler.sv
// Bench for digit_write_scheduler: drives directed manual/scroll traffic
// against a behavioural register bank and scores every write in order.
module tb_digit_write_scheduler;
  localparam int N_DIG = 8;
  localparam int DW    = 4;
  localparam int SW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          man_req;
  logic [SW-1:0] man_sel;
  logic [DW-1:0] man_data;
  logic          man_gnt;
  logic          scr_req;
  logic [DW-1:0] scr_data;
  logic          scr_ack;
  logic          scr_done;
  logic          busy;
  logic          wr_en;
  logic [SW-1:0] wr_sel;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] rd_sel;
  logic [DW-1:0] rd_data;

  digit_write_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .man_req  (man_req),
    .man_sel  (man_sel),
    .man_data (man_data),
    .man_gnt  (man_gnt),
    .scr_req  (scr_req),
    .scr_data (scr_data),
    .scr_ack  (scr_ack),
    .scr_done (scr_done),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  // Register bank the scheduler drives.
  logic [DW-1:0] bank [N_DIG];
  assign rd_data = bank[rd_sel];
  always @(posedge clk) if (wr_en) bank[wr_sel] <= wr_data;

  // kind: 0 manual write, 1 shift write, 2 insert write; gap -1 = don't care
  typedef struct {
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
    int            kind;
    int            gap;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   errors   = 0;
  int   idle_run = 0;

  task automatic push(input logic [SW-1:0] s, input logic [DW-1:0] d, input int k, input int g);
    exp_t e;
    e.sel = s; e.data = d; e.kind = k; e.gap = g;
    expq.push_back(e);
  endtask

  // pre holds the bank before the scroll, digit i at pre[i*DW +: DW]
  task automatic push_scroll(input logic [N_DIG*DW-1:0] pre, input logic [DW-1:0] d, input int g0);
    for (int i = N_DIG - 1; i >= 1; i--)
      push(SW'(i), pre[(i-1)*DW +: DW], 1, (i == N_DIG - 1) ? g0 : 0);
    push('0, d, 2, 0);
  endtask

  // Scoreboard monitor: one comparison per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (wr_en) begin
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got sel %0d data %h, expected no write", wr_sel, wr_data);
      end else begin
        e = expq.pop_front();
        if (wr_sel !== e.sel || wr_data !== e.data || man_gnt !== (e.kind == 0) ||
            scr_done !== (e.kind == 2) || (e.gap >= 0 && idle_run != e.gap)) begin
          errors++;
          $display("FAIL write: got sel %0d data %h gnt %b done %b gap %0d, want sel %0d data %h gnt %b done %b gap %0d",
                   wr_sel, wr_data, man_gnt, scr_done, idle_run,
                   e.sel, e.data, (e.kind == 0), (e.kind == 2), e.gap);
        end
      end
      idle_run = 0;
    end else begin
      if (man_gnt !== 1'b0 || scr_done !== 1'b0) begin
        errors++;
        $display("FAIL idle_pulse: got gnt %b done %b, want 0 0", man_gnt, scr_done);
      end
      idle_run++;
    end
  end

  task automatic chk_quiet(input string nm);
    logic [18:0] act;
    act = {wr_en, busy, man_gnt, scr_done, scr_ack, wr_sel, wr_data, rd_sel, 1'b0};
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL %s: outputs got %h want 0", nm, act);
    end
  endtask

  task automatic check_bank(input string nm, input logic [N_DIG*DW-1:0] want);
    logic [N_DIG*DW-1:0] act;
    for (int i = 0; i < N_DIG; i++) act[i*DW +: DW] = bank[i];
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: bank(d7..d0) got %h want %h", nm, act, want);
    end
  endtask

  task automatic wait_gnt(input string nm);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!man_gnt && n < 40);
    checks++;
    if (man_gnt !== 1'b1) begin
      errors++;
      $display("FAIL %s: man_gnt got %b want 1 within 40 cycles", nm, man_gnt);
    end
  endtask

  task automatic wait_ack(input string nm);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!scr_ack && n < 40);
    checks++;
    if (scr_ack !== 1'b1) begin
      errors++;
      $display("FAIL %s: scr_ack got %b want 1 within 40 cycles", nm, scr_ack);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (busy && n < 40);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy got %b want 0 within 40 cycles", nm, busy);
    end
  endtask

  task automatic man_write(input logic [SW-1:0] s, input logic [DW-1:0] d, input int g, input string nm);
    push(s, d, 0, g);
    man_sel  = s;
    man_data = d;
    man_req  = 1'b1;
    wait_gnt(nm);
    man_req  = 1'b0;
  endtask

  initial begin
    int mg, sa, n;
    rst = 1'b0; man_req = 1'b0; man_sel = '0; man_data = '0;
    scr_req = 1'b0; scr_data = '0;
    repeat (2) @(posedge clk);
    #1 chk_quiet("reset_outputs");
    rst = 1'b1;
    @(posedge clk); #1 chk_quiet("after_reset_idle");

    // Single manual write, then the scheduler goes idle.
    man_write(3'd3, 4'hA, -1, "man_single");
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL man_busy_clear: busy got %b want 0", busy); end

    // Back-to-back manual writes, two cycles apart.
    for (int i = 0; i < N_DIG; i++) man_write(SW'(i), DW'(8 + i), (i == 0) ? -1 : 1, "man_b2b_8F");
    wait_idle("man_b2b_8F_idle");
    check_bank("bank_8_to_F", 32'hFEDCBA98);

    for (int i = 0; i < N_DIG; i++) man_write(SW'(i), DW'(i), (i == 0) ? -1 : 1, "man_preload");
    wait_idle("preload_idle");
    check_bank("bank_preload", 32'h76543210);

    // Plain scroll inserting F.
    push_scroll(32'h76543210, 4'hF, -1);
    scr_data = 4'hF; scr_req = 1'b1;
    wait_ack("scroll_F_ack");
    scr_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (scr_ack !== 1'b0) begin errors++; $display("FAIL ack_pulse: scr_ack got %b want 0", scr_ack); end
    wait_idle("scroll_F_idle");
    check_bank("scroll_F", 32'h6543210F);

    // Manual request raised in the 3rd shift cycle, scroll re-requested too.
    push_scroll(32'h6543210F, 4'h9, -1);
    push(3'd2, 4'h7, 0, 1);
    push_scroll(32'h543217F9, 4'h1, 1);
    scr_data = 4'h9; scr_req = 1'b1;
    wait_ack("mid_scroll_ack");
    scr_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    man_sel = 3'd2; man_data = 4'h7; man_req = 1'b1;
    scr_data = 4'h1; scr_req = 1'b1;
    wait_gnt("mid_man_gnt");
    man_req = 1'b0;
    wait_ack("mid_scroll2_ack");
    scr_req = 1'b0;
    wait_idle("mid_idle");
    check_bank("mid_scroll_bank", 32'h43217F91);

    // Fresh reset, then both held: grants must alternate M,S,M,S.
    @(posedge clk); #1 rst = 1'b0;
    #1 chk_quiet("reset2_outputs");
    @(posedge clk); #1 rst = 1'b1;
    push(3'd0, 4'hA, 0, -1);
    push_scroll(32'h43217F9A, 4'hB, 1);
    push(3'd7, 4'hC, 0, 1);
    push_scroll(32'hC217F9AB, 4'hD, 1);
    man_sel = 3'd0; man_data = 4'hA; man_req = 1'b1;
    scr_data = 4'hB; scr_req = 1'b1;
    mg = 0; sa = 0; n = 0;
    while (!(mg == 2 && sa == 2 && !busy) && n < 100) begin
      @(posedge clk); #1; n++;
      if (man_gnt) begin
        mg++;
        if (mg == 1) begin man_sel = 3'd7; man_data = 4'hC; end
        else man_req = 1'b0;
      end
      if (scr_ack) begin
        sa++;
        if (sa == 1) scr_data = 4'hD;
        else scr_req = 1'b0;
      end
    end
    man_req = 1'b0; scr_req = 1'b0;
    checks++;
    if (mg != 2 || sa != 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL alternate_grants: got gnt %0d ack %0d busy %b want 2 2 0", mg, sa, busy);
    end
    check_bank("alternate_bank", 32'h217F9ABD);

    // Reset during the 4th shift cycle: only d7..d5 have been written.
    push(3'd7, 4'h1, 1, -1);
    push(3'd6, 4'h7, 1, 0);
    push(3'd5, 4'hF, 1, 0);
    scr_data = 4'hE; scr_req = 1'b1;
    wait_ack("rst_mid_ack");
    scr_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk_quiet("rst_mid_outputs");
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_pending: writes left got %0d want 0", expq.size());
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 chk_quiet("post_rst_idle");
    check_bank("rst_mid_bank", 32'h17FF9ABD);

    man_write(3'd4, 4'h0, -1, "post_rst_man");
    @(posedge clk); #1;
    check_bank("post_rst_bank", 32'h17F09ABD);

    @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL leftover_writes: got %0d want 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_write_scheduler.md
Name: digit_write_scheduler

Overview:
- Sequences and shares the single write port of the 8-digit x 4-bit display register bank between two requesters.
- Requester 0: manual switch writes (one digit at a time).
- Requester 1: a scroll engine that shifts all digits up by one position and inserts a new nibble at digit 0, using the bank's read mux.
- Sits between the user inputs and the enable-decode/register bank. It replaces the direct wr/sel gating, and its write-active flag drives the anode-select mux.

Parameters:
- N_DIG, 8, number of digit registers (power of 2, >= 2).
- DW, 4, digit data width.
- SW, $clog2(N_DIG), digit index width (derived; not overridden).

Ports:
- clk  in  1  system clock (post down-clocking).
- rst  in  1  reset, asynchronous, active-low.
- man_req  in  1  manual write request (level); held with sel/data until man_gnt.
- man_sel  in  SW  manual target digit.
- man_data  in  DW  manual write data.
- man_gnt  out  1  one-cycle pulse in the cycle the manual write is issued.
- scr_req  in  1  scroll request (level); held until scr_ack.
- scr_data  in  DW  nibble to insert at digit 0.
- scr_ack  out  1  one-cycle pulse on the edge the scroll is accepted.
- scr_done  out  1  one-cycle pulse in the final (insert) write cycle.
- busy  out  1  high in any state other than IDLE.
- wr_en  out  1  write enable to the register bank.
- wr_sel  out  SW  digit index written.
- wr_data  out  DW  data written.
- rd_sel  out  SW  read-mux select into the bank.
- rd_data  in  DW  combinational read data for rd_sel (current register contents).

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, idx=N_DIG-1, last_gnt=SCROLL (manual wins the first tie).
  - All outputs 0; latched sel/data = 0.
- FSM states: IDLE, MAN_WR, SHIFT, INSERT. Outputs are decoded from registered state (Moore).
- IDLE:
  - wr_en=0, rd_sel=0.
  - Only man_req=1: latch man_sel/man_data -> MAN_WR.
  - Only scr_req=1: latch scr_data, pulse scr_ack (registered, visible in the first SHIFT cycle), idx<=N_DIG-1 -> SHIFT.
  - Both set: round-robin; grant the requester not in last_gnt, then update last_gnt.
- MAN_WR (1 cycle):
  - wr_en=1, wr_sel/wr_data from the latched values, man_gnt=1 -> IDLE.
- SHIFT (N_DIG-1 cycles):
  - rd_sel=idx-1, wr_en=1, wr_sel=idx, wr_data=rd_data.
  - idx decrements each cycle; when idx==1 -> INSERT.
  - Descending order guarantees the source digit is not yet overwritten.
- INSERT (1 cycle):
  - wr_en=1, wr_sel=0, wr_data=latched scr_data, scr_done=1 -> IDLE.
- Latency:
  - Manual: write lands one edge after acceptance.
  - Scroll: N_DIG write cycles (8 by default) after acceptance.
  - At least one IDLE cycle separates consecutive operations.
- Bursts are not preemptible. man_req arriving mid-scroll waits; on return to IDLE it beats a re-asserted scr_req, because last_gnt=SCROLL.
- man_req deasserted before man_gnt: illegal (requester contract). The scheduler still completes the latched write.
- Reset mid-scroll: the operation aborts immediately and wr_en drops asynchronously. Already-written digits keep their partially shifted values. No scr_done is issued.
- Only one of man_gnt and scr_done can be high in any cycle. wr_en is high exactly in MAN_WR, SHIFT and INSERT.
- Width rules:
  - idx is SW bits; it never wraps below 1 in SHIFT.
  - wr_sel/rd_sel are zero-extended nowhere; all indices are exactly SW bits.

Decomposition:
- Shared package disp_pkg:
  - typedef enum logic [1:0] {IDLE, MAN_WR, SHIFT, INSERT} wsched_state_t.
  - typedef enum logic {MANUAL, SCROLL} req_id_t.
  - localparams N_DIG=8, DW=4.
- One sub-module is natural: rr_arb2, a 2-requester round-robin arbiter holding last_gnt and enabled only in IDLE.
- The FSM, idx counter and data latches stay in the top module.

Test Plan:
- Reset, then man_req=1, man_sel=3, man_data=4'hA -> the cycle after acceptance has wr_en=1, wr_sel=3, wr_data=A, man_gnt=1; next cycle busy=0.
- Bank preloaded 0..7 (digit i = i), scr_req with scr_data=4'hF -> writes in order d7<=6, d6<=5, ..., d1<=0, d0<=F over 8 cycles. scr_done is high in the d0 cycle only; final bank is F,0,1,...,6.
- man_req and scr_req asserted together after reset -> manual is granted first, then scroll. Repeated with both held: grants alternate M,S,M,S.
- man_req raised in the 3rd SHIFT cycle -> no wr_en glitch and the scroll completes. The manual write issues after one IDLE cycle, ahead of a held scr_req.
- rst pulsed low during the 4th SHIFT cycle -> outputs 0 immediately, no scr_done. Digits 7..5 hold shifted values and the rest are unchanged; after release, state is IDLE.
- Back-to-back manual writes to digits 0..7 with data 8..F -> each write is spaced 2 cycles apart and the bank reads 8..F.
